// File: rtl/jtgng_sndrom_arb.sv
// Two-client sound ROM arbiter with a one-entry read cache per client.
// Define JTGNG_SNDROM_FIXPRIO_EN for fixed priority (client 0 wins ties); default is round-robin.
module jtgng_sndrom_arb #(
  parameter int AW0 = 15,
  parameter int AW1 = 15,
  parameter int OW  = 22,
  parameter logic [OW-1:0] BASE0 = OW'(22'h0),
  parameter logic [OW-1:0] BASE1 = OW'(22'h8000)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cs0,
  input  logic [AW0-1:0] addr0,
  output logic [7:0]     dout0,
  output logic           ok0,
  input  logic           cs1,
  input  logic [AW1-1:0] addr1,
  output logic [7:0]     dout1,
  output logic           ok1,
  output logic [OW-1:0]  rom_addr,
  output logic           rom_req,
  input  logic           rom_ack,
  input  logic           rom_ok,
  input  logic [7:0]     rom_data
);

  localparam int AW = (AW0 > AW1) ? AW0 : AW1;

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

  state_t         state, state_nx;
  logic           gnt, gnt_nx;
  logic [AW-1:0]  lat, lat_nx;
  logic [OW-1:0]  rom_addr_nx;
  logic           rom_req_nx;
  logic           wr;
  logic           pend0, pend1, pick1;
  logic           valid0, valid1;
  logic [AW0-1:0] tag0;
  logic [AW1-1:0] tag1;
  logic [7:0]     data0, data1;
`ifndef JTGNG_SNDROM_FIXPRIO_EN
  logic           last, last_nx;  // 1: client 1 was served most recently
`endif

  assign ok0   = cs0 && valid0 && (addr0 == tag0);
  assign ok1   = cs1 && valid1 && (addr1 == tag1);
  assign dout0 = data0;
  assign dout1 = data1;
  assign pend0 = cs0 && !ok0;
  assign pend1 = cs1 && !ok1;

`ifdef JTGNG_SNDROM_FIXPRIO_EN
  assign pick1 = pend1 && !pend0;
`else
  assign pick1 = pend1 && (!pend0 || !last);
`endif

  always_comb begin
    state_nx    = state;
    gnt_nx      = gnt;
    lat_nx      = lat;
    rom_addr_nx = rom_addr;
    rom_req_nx  = rom_req;
    wr          = 1'b0;
`ifndef JTGNG_SNDROM_FIXPRIO_EN
    last_nx     = last;
`endif
    case (state)
      IDLE: begin
        if (pend0 || pend1) begin
          gnt_nx      = pick1;
          lat_nx      = pick1 ? AW'(addr1) : AW'(addr0);
          rom_addr_nx = pick1 ? BASE1 + OW'(addr1) : BASE0 + OW'(addr0);
          rom_req_nx  = 1'b1;
          state_nx    = REQ;
`ifndef JTGNG_SNDROM_FIXPRIO_EN
          last_nx     = pick1;
`endif
        end
      end
      REQ: begin
        if (rom_ack) begin
          rom_req_nx = 1'b0;
          // a downstream that answers in the ack cycle completes immediately
          if (rom_ok) begin
            wr       = 1'b1;
            state_nx = IDLE;
          end else begin
            state_nx = DATA;
          end
        end
      end
      DATA: begin
        if (rom_ok) begin
          wr       = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt      <= 1'b0;
      lat      <= '0;
      rom_addr <= '0;
      rom_req  <= 1'b0;
      valid0   <= 1'b0;
      valid1   <= 1'b0;
      tag0     <= '0;
      tag1     <= '0;
      data0    <= '0;
      data1    <= '0;
`ifndef JTGNG_SNDROM_FIXPRIO_EN
      last     <= 1'b1;
`endif
    end else begin
      gnt      <= gnt_nx;
      lat      <= lat_nx;
      rom_addr <= rom_addr_nx;
      rom_req  <= rom_req_nx;
`ifndef JTGNG_SNDROM_FIXPRIO_EN
      last     <= last_nx;
`endif
      // tag comes from the address latched at grant, not the live address
      if (wr && !gnt) begin
        valid0 <= 1'b1;
        tag0   <= AW0'(lat);
        data0  <= rom_data;
      end
      if (wr && gnt) begin
        valid1 <= 1'b1;
        tag1   <= AW1'(lat);
        data1  <= rom_data;
      end
    end
  end

endmodule

// File: tb/tb_jtgng_sndrom_arb.sv
// Directed bench for jtgng_sndrom_arb (default round-robin build) with a hand-driven downstream.
module tb_jtgng_sndrom_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic        cs0, cs1;
  logic [14:0] addr0, addr1;
  logic [7:0]  dout0, dout1;
  logic        ok0, ok1;
  logic [21:0] rom_addr;
  logic        rom_req;
  logic        rom_ack, rom_ok;
  logic [7:0]  rom_data;

  int checks   = 0;
  int failures = 0;

  jtgng_sndrom_arb dut (
    .clk(clk), .rst(rst),
    .cs0(cs0), .addr0(addr0), .dout0(dout0), .ok0(ok0),
    .cs1(cs1), .addr1(addr1), .dout1(dout1), .ok1(ok1),
    .rom_addr(rom_addr), .rom_req(rom_req),
    .rom_ack(rom_ack), .rom_ok(rom_ok), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  // inputs are driven 2 time units after the rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // called in REQ with rom_req high: ack one cycle, then data one cycle later
  task automatic serve(input logic [7:0] d);
    rom_ack = 1'b1;
    tick();
    rom_ack  = 1'b0;
    rom_ok   = 1'b1;
    rom_data = d;
    tick();
    rom_ok = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; cs0 = 0; cs1 = 0; addr0 = '0; addr1 = '0;
    rom_ack = 0; rom_ok = 0; rom_data = '0;
    #3;
    chk("rst_ok0", ok0, 0);
    chk("rst_ok1", ok1, 0);
    chk("rst_dout0", dout0, 0);
    chk("rst_dout1", dout1, 0);
    chk("rst_rom_req", rom_req, 0);
    chk("rst_rom_addr", rom_addr, 0);
    tick();
    rst = 1'b0;
    tick();

    // basic miss, 3-cycle latency, then hit
    cs0 = 1; addr0 = 15'h0100;
    #1 chk("miss_ok0_c0", ok0, 0);
    tick();
    chk("miss_req", rom_req, 1);
    chk("miss_addr", rom_addr, 22'h0100);
    rom_ack = 1;
    tick();
    chk("miss_req_clr", rom_req, 0);
    chk("miss_ok0_c2", ok0, 0);
    rom_ack = 0; rom_ok = 1; rom_data = 8'h3C;
    tick();
    rom_ok = 0;
    #1;
    chk("miss_ok0_c3", ok0, 1);
    chk("miss_dout0", dout0, 8'h3C);
    cs0 = 0;
    tick();
    cs0 = 1; addr0 = 15'h0100;
    #1 chk("hit_ok0", ok0, 1);
    tick();
    chk("hit_no_req", rom_req, 0);
    cs0 = 0;
    tick();

    // ack and ok together in REQ
    cs0 = 1; addr0 = 15'h0200;
    tick();
    chk("same_addr", rom_addr, 22'h0200);
    rom_ack = 1; rom_ok = 1; rom_data = 8'h5A;
    tick();
    rom_ack = 0; rom_ok = 0;
    #1;
    chk("same_ok0", ok0, 1);
    chk("same_dout0", dout0, 8'h5A);
    chk("same_req", rom_req, 0);
    cs0 = 0;
    tick();

    // ack withheld for 5 cycles
    cs0 = 1; addr0 = 15'h0300;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall_req_%0d", i), rom_req, 1);
      chk($sformatf("stall_addr_%0d", i), rom_addr, 22'h0300);
      chk($sformatf("stall_ok0_%0d", i), ok0, 0);
      tick();
    end
    serve(8'hA5);
    chk("stall_ok0_done", ok0, 1);
    chk("stall_dout0", dout0, 8'hA5);

    // address change while in DATA
    addr0 = 15'h0100;
    tick();
    chk("chg_addr_old", rom_addr, 22'h0100);
    rom_ack = 1;
    tick();
    rom_ack = 0;
    addr0 = 15'h0101;
    #1 chk("chg_ok0_data", ok0, 0);
    rom_ok = 1; rom_data = 8'h11;
    tick();
    rom_ok = 0;
    #1;
    chk("chg_ok0_mismatch", ok0, 0);
    chk("chg_dout0_old", dout0, 8'h11);
    tick();
    chk("chg_rereq", rom_req, 1);
    chk("chg_addr_new", rom_addr, 22'h0101);
    chk("chg_ok0_wait", ok0, 0);
    serve(8'h22);
    chk("chg_ok0_new", ok0, 1);
    chk("chg_dout0_new", dout0, 8'h22);
    cs0 = 0;

    // arbitration from a fresh reset
    rst = 1;
    tick();
    rst = 0;
    cs0 = 1; addr0 = 15'h0010;
    cs1 = 1; addr1 = 15'h0020;
    tick();
    chk("arb1_addr", rom_addr, 22'h0010);
    serve(8'h77);
    chk("arb1_ok0", ok0, 1);
    chk("arb1_dout0", dout0, 8'h77);
    chk("arb1_ok1", ok1, 0);
    tick();
    chk("arb2_addr", rom_addr, 22'h8020);
    serve(8'h88);
    chk("arb2_ok1", ok1, 1);
    chk("arb2_dout1", dout1, 8'h88);
    addr0 = 15'h0050;
    tick();
    chk("solo_addr", rom_addr, 22'h0050);
    serve(8'h55);
    chk("solo_ok0", ok0, 1);
    addr0 = 15'h0060; addr1 = 15'h0070;
    tick();
    chk("rr_first_addr", rom_addr, 22'h8070);
    serve(8'h99);
    chk("rr_ok1", ok1, 1);
    chk("rr_dout1", dout1, 8'h99);
    chk("rr_ok0_wait", ok0, 0);
    tick();
    chk("rr_second_addr", rom_addr, 22'h0060);
    serve(8'h66);
    chk("rr_ok0", ok0, 1);
    chk("rr_dout0", dout0, 8'h66);
    cs1 = 0;

    // reset while in DATA, late rom_ok ignored
    addr0 = 15'h0080;
    tick();
    rom_ack = 1;
    tick();
    rom_ack = 0;
    rst = 1; cs0 = 0;
    #1;
    chk("rstd_req", rom_req, 0);
    chk("rstd_dout1", dout1, 0);
    tick();
    rst = 0;
    tick();
    rom_ok = 1; rom_data = 8'hEE;
    tick();
    rom_ok = 0;
    cs0 = 1; addr0 = 15'h0080;
    #1;
    chk("rstd_ok0", ok0, 0);
    chk("rstd_dout0", dout0, 0);
    tick();
    chk("rstd_rereq", rom_req, 1);
    chk("rstd_readdr", rom_addr, 22'h0080);
    serve(8'h42);
    chk("rstd_ok0_fill", ok0, 1);
    chk("rstd_dout0_fill", dout0, 8'h42);
    cs0 = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/jtgng_sndrom_arb.md
JTGNG_SNDROM_ARB -- requirements
Module: jtgng_sndrom_arb

Interface
REQ-001 Parameter AW0, default 15: address width of requester 0 (sound CPU ROM port).
REQ-002 Parameter AW1, default 15: address width of requester 1 (auxiliary sound ROM client).
REQ-003 Parameter OW, default 22: downstream ROM/SDRAM word address width.
REQ-004 Parameter BASE0, default 22'h0: downstream offset added to requester 0 address.
REQ-005 Parameter BASE1, default 22'h8000: downstream offset added to requester 1 address.
REQ-006 clk  in  1  system clock (24 MHz); one clock only; rst  in  1  asynchronous, active-high reset.
REQ-007 cs0  in  1  requester 0 read strobe; addr0  in  AW0  requester 0 byte address.
REQ-008 dout0  out  8  requester 0 read data; ok0  out  1  requester 0 data valid (drives Z80 WAIT_n when cs0).
REQ-009 cs1, addr1 (AW1), dout1 (8), ok1: same meaning for requester 1.
REQ-010 rom_addr  out  OW  downstream address; rom_req  out  1  downstream request.
REQ-011 rom_ack  in  1  downstream accepted request; rom_ok  in  1  downstream data valid; rom_data  in  8  downstream data.

Function
REQ-012 Each requester SHALL own a one-entry cache: valid bit, tag address, 8-bit data.
REQ-013 okN SHALL be combinational: csN && validN && (addrN == tagN); doutN SHALL always equal cached dataN.
REQ-014 A requester is pending when csN is high and okN is low.
REQ-015 FSM states IDLE, REQ, DATA; only IDLE SHALL grant.
REQ-016 IDLE: if any pending, latch grant, drive rom_addr = BASEn + addrn (zero-extended), set rom_req, go REQ; grant latched on the same edge.
REQ-017 REQ: hold rom_req and rom_addr stable until rom_ack; on rom_ack clear rom_req, go DATA.
REQ-018 DATA: on rom_ok write rom_data into the granted cache, tag = address latched at grant, valid = 1, go IDLE.
REQ-019 rom_ack and rom_ok on the same cycle in REQ SHALL complete the transfer directly (REQ -> IDLE, cache written).
REQ-020 Latency: miss with idle arbiter and zero-wait downstream SHALL give okN high 3 clk after csN rises; hit SHALL give okN same cycle.
REQ-021 Address change while a request is in flight SHALL NOT abort it; the cache fills with the old address, then the new address misses and re-requests.
REQ-022 csN dropping mid-transfer SHALL NOT abort the transfer; the cache is still filled.
REQ-023 Arbitration when both pending in IDLE: round-robin; the requester not served last wins; after reset requester 0 wins first.
REQ-024 Cache entries SHALL never be invalidated except by reset.
REQ-025 rom_ok outside DATA/REQ SHALL be ignored.

Reset
REQ-026 rst high SHALL asynchronously force: state IDLE, rom_req 0, rom_addr 0, valid0/valid1 0, tags 0, data 0, last-served = 1 (so requester 0 wins first).
REQ-027 Reset mid-transfer SHALL drop rom_req at once; the late rom_ok SHALL be ignored, with no cache write.
REQ-028 Outputs during reset: ok0 = ok1 = 0, dout0 = dout1 = 0, rom_req = 0.

Configuration
REQ-029 Macro JTGNG_SNDROM_FIXPRIO_EN defined: fixed priority; requester 0 SHALL always win a tie; last-served register unused.
REQ-030 Macro undefined: round-robin per REQ-023.

Verification
REQ-031 Reset, cs0 = 1, addr0 = 15'h0100, rom_data = 8'h3C with ack/ok one cycle after req -> rom_addr = 22'h0100, ok0 high 3 clk after cs0, dout0 = 8'h3C; second read of 0100 -> ok0 same cycle, no rom_req.
REQ-032 cs0 and cs1 rise together, addr0 = 0010, addr1 = 0020 -> first rom_addr = 22'h0010, second = 22'h8020; third simultaneous miss pair -> requester 1 first (round-robin); with JTGNG_SNDROM_FIXPRIO_EN -> requester 0 first each time.
REQ-033 Hold rom_ack low 5 clk -> rom_req and rom_addr stable throughout; ok0 low until rom_ok.
REQ-034 Change addr0 from 0100 to 0101 while in DATA -> cache holds 0100 data, then new request at 22'h0101; ok0 low until that completes.
REQ-035 Assert rst while in DATA, pulse rom_ok 2 clk later -> no cache write, valid0 = 0, next cs0 re-requests.
REQ-036 rom_ack and rom_ok in the same cycle -> single-cycle completion, ok0 high next cycle.
